mult_host: RTL

MULT_HOST -- requirements
Module: mult_host

---
 rtl/mult_host.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mult_host.sv
// mult_host: collects 64 operand pairs, bursts them to an external multiplier, then drains
// the multiplier's block readout as a result stream. Define MULT_HOST_SUM_EN to enable sum_out.
module mult_host #(
  parameter int DEPTH = 64,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         EN_mult,
  output logic [W-1:0] mult_input0,
  output logic [W-1:0] mult_input1,
  input  logic         RDY_mult,
  output logic         EN_blockRead,
  input  logic         VALID_memVal,
  input  logic [W-1:0] memVal_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         err,
  output logic [21:0]  sum_out
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [7:0]    WD_LIMIT = 8'd254;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    BURST,
    WAIT_FULL,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [AW-1:0]  fill_cnt;
  logic [AW-1:0]  burst_cnt;
  logic [AW-1:0]  drain_cnt;
  logic [AW-1:0]  burst_idx_next;
  logic [7:0]     wd_cnt;
  logic [2*W-1:0] mem [DEPTH];
  logic [2*W-1:0] burst_pair;
  logic           accept;
  logic           beat;
  logic           wd_expire;
  logic           start_read;

  // in_ready is combinational so the producer sees it in the same cycle FILL is entered.
  assign in_ready       = (state == FILL) && !rst;
  assign accept         = in_valid && in_ready;
  assign beat           = (state == DRAIN) && VALID_memVal;
  assign wd_expire      = (state == DRAIN) && !VALID_memVal && (wd_cnt == WD_LIMIT);
  assign start_read     = (state == WAIT_FULL) && !RDY_mult;
  assign burst_idx_next = (state == BURST) ? burst_cnt + AW'(1) : '0;
  assign burst_pair     = mem[burst_idx_next];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (RDY_mult) begin
          state_next = FILL;
        end
      end
      FILL: begin
        if (accept && (fill_cnt == LAST_IDX)) begin
          state_next = BURST;
        end
      end
      BURST: begin
        if (burst_cnt == LAST_IDX) begin
          state_next = WAIT_FULL;
        end
      end
      WAIT_FULL: begin
        if (!RDY_mult) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (beat && (drain_cnt == LAST_IDX)) begin
          state_next = DONE;
        end else if (wd_expire) begin
          state_next = IDLE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand buffer is deliberately left out of reset; entries are rewritten before every burst.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[fill_cnt] <= {in_a, in_b};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt  <= '0;
      burst_cnt <= '0;
      drain_cnt <= '0;
      wd_cnt    <= '0;
    end else begin
      if (state != FILL) begin
        fill_cnt <= '0;
      end else if (accept) begin
        fill_cnt <= fill_cnt + AW'(1);
      end

      burst_cnt <= (state_next == BURST) ? burst_idx_next : '0;

      if ((state != DRAIN) || wd_expire) begin
        drain_cnt <= '0;
        wd_cnt    <= '0;
      end else if (beat) begin
        drain_cnt <= drain_cnt + AW'(1);
        wd_cnt    <= '0;
      end else begin
        wd_cnt <= wd_cnt + 8'd1;
      end
    end
  end

  // Burst outputs are loaded from the upcoming state so EN_mult is high exactly in BURST cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      EN_mult      <= 1'b0;
      mult_input0  <= '0;
      mult_input1  <= '0;
      EN_blockRead <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
      err          <= 1'b0;
    end else begin
      EN_mult      <= (state_next == BURST);
      mult_input0  <= (state_next == BURST) ? burst_pair[2*W-1:W] : '0;
      mult_input1  <= (state_next == BURST) ? burst_pair[W-1:0] : '0;
      EN_blockRead <= start_read;
      out_valid    <= beat;
      out_data     <= beat ? memVal_data : '0;
      out_last     <= beat && (drain_cnt == LAST_IDX);
      err          <= wd_expire;
    end
  end

`ifdef MULT_HOST_SUM_EN
  logic [21:0] sum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else if (start_read) begin
      sum_q <= '0;
    end else if (beat) begin
      sum_q <= sum_q + 22'(memVal_data);
    end
  end

  assign sum_out = sum_q;
`else
  assign sum_out = '0;
`endif

endmodule
